// File: rtl/halflife_btn_cond.sv
// halflife_btn_cond: synchronise, debounce and strobe the up/down/load buttons.
// Define HALFLIFE_AUTO_REPEAT_EN to build the held-button auto-repeat logic.
module halflife_btn_cond #(
  parameter int DB_CYCLES  = 8,
  parameter int RPT_DELAY  = 32,
  parameter int RPT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up_btn,
  input  logic down_btn,
  input  logic load_btn,
  output logic up_level,
  output logic down_level,
  output logic up_pulse,
  output logic down_pulse,
  output logic load_pulse
);

  localparam int DBW = $clog2(DB_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef HALFLIFE_AUTO_REPEAT_EN
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
`else
  localparam logic [1:0] S_HELD   = 2'd1;
`endif
  localparam logic [1:0] S_LOCK   = 2'd3;

  if (DB_CYCLES < 2 || RPT_PERIOD < 2 ||
      RPT_DELAY < RPT_PERIOD) begin : g_bad_cfg
    $error("halflife_btn_cond: illegal parameters");
  end

  // channel order: 0 = up, 1 = down, 2 = load
  logic [2:0]     w_raw;
  logic [2:0]     r_s1;
  logic [2:0]     r_s2;
  logic [2:0]     r_lvl;
  logic [2:0]     w_nxt;
  logic [DBW-1:0] r_dbc [3];

  assign w_raw = {load_btn, down_btn, up_btn};

  always_comb begin
    w_nxt = r_lvl;
    for (int i = 0; i < 3; i++) begin
      if (r_s2[i] != r_lvl[i] && r_dbc[i] == DB_LAST)
        w_nxt[i] = r_s2[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_lvl <= '0;
      for (int i = 0; i < 3; i++)
        r_dbc[i] <= '0;
    end else begin
      r_s1  <= w_raw;
      r_s2  <= r_s1;
      r_lvl <= w_nxt;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_lvl[i] || r_dbc[i] == DB_LAST)
          r_dbc[i] <= '0;
        else
          r_dbc[i] <= r_dbc[i] + DBW'(1);
      end
    end
  end

  // FSMs act on the level being registered this edge,
  // so the press strobe lands in the level's first cycle
  logic [1:0] r_st   [2];
  logic [1:0] w_st_n [2];
  logic [1:0] w_strb;
  logic       w_both;
  logic       w_ld_rise;

  assign w_both    = w_nxt[0] & w_nxt[1];
  assign w_ld_rise = w_nxt[2] & ~r_lvl[2];

`ifdef HALFLIFE_AUTO_REPEAT_EN
  localparam int RW = $clog2(RPT_DELAY) + 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(RPT_PERIOD - 1);

  logic [RW-1:0] r_rc   [2];
  logic [RW-1:0] w_rc_n [2];

  always_comb begin
    w_strb = '0;
    for (int i = 0; i < 2; i++) begin
      w_st_n[i] = r_st[i];
      w_rc_n[i] = r_rc[i];
      if (w_both) begin
        w_st_n[i] = S_LOCK;
        w_rc_n[i] = '0;
      end else begin
        unique case (1'b1)
          (r_st[i] == S_IDLE): begin
            if (w_nxt[i]) begin
              w_strb[i] = 1'b1;
              w_st_n[i] = S_DELAY;
              w_rc_n[i] = '0;
            end
          end
          (r_st[i] == S_DELAY): begin
            if (!w_nxt[i]) begin
              w_st_n[i] = S_IDLE;
              w_rc_n[i] = '0;
            end else if (r_rc[i] == DLY_LAST) begin
              w_strb[i] = 1'b1;
              w_st_n[i] = S_REPEAT;
              w_rc_n[i] = '0;
            end else begin
              w_rc_n[i] = r_rc[i] + RW'(1);
            end
          end
          (r_st[i] == S_REPEAT): begin
            if (!w_nxt[i]) begin
              w_st_n[i] = S_IDLE;
              w_rc_n[i] = '0;
            end else if (r_rc[i] == PER_LAST) begin
              w_strb[i] = 1'b1;
              w_rc_n[i] = '0;
            end else begin
              w_rc_n[i] = r_rc[i] + RW'(1);
            end
          end
          default: begin
            w_rc_n[i] = '0;
            if (!w_nxt[i])
              w_st_n[i] = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc[0] <= '0;
      r_rc[1] <= '0;
    end else begin
      r_rc[0] <= w_rc_n[0];
      r_rc[1] <= w_rc_n[1];
    end
  end
`else
  always_comb begin
    w_strb = '0;
    for (int i = 0; i < 2; i++) begin
      w_st_n[i] = r_st[i];
      if (w_both) begin
        w_st_n[i] = S_LOCK;
      end else begin
        unique case (1'b1)
          (r_st[i] == S_IDLE): begin
            if (w_nxt[i]) begin
              w_strb[i] = 1'b1;
              w_st_n[i] = S_HELD;
            end
          end
          (r_st[i] == S_HELD): begin
            if (!w_nxt[i])
              w_st_n[i] = S_IDLE;
          end
          default: begin
            if (!w_nxt[i])
              w_st_n[i] = S_IDLE;
          end
        endcase
      end
    end
  end
`endif

  logic r_up_p;
  logic r_dn_p;
  logic r_ld_p;

  // load wins: a masked up/down strobe is dropped, FSM timing is not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st[0] <= S_IDLE;
      r_st[1] <= S_IDLE;
      r_up_p  <= 1'b0;
      r_dn_p  <= 1'b0;
      r_ld_p  <= 1'b0;
    end else begin
      r_st[0] <= w_st_n[0];
      r_st[1] <= w_st_n[1];
      r_up_p  <= w_strb[0] & ~w_ld_rise;
      r_dn_p  <= w_strb[1] & ~w_ld_rise;
      r_ld_p  <= w_ld_rise;
    end
  end

  assign up_level   = r_lvl[0];
  assign down_level = r_lvl[1];
  assign up_pulse   = r_up_p;
  assign down_pulse = r_dn_p;
  assign load_pulse = r_ld_p;

endmodule

// File: doc/halflife_btn_cond.md
Name: halflife_btn_cond

Overview:
Input conditioner that sits directly upstream of the half-life up/down counter.
- Synchronises, debounces and edge-detects the raw up, down and load push-buttons.
- Produces clean single-cycle command strobes, with auto-repeat on held up/down buttons.
- Its strobes drive the counter's up, down and load-strobe inputs; the 4-bit load value bypasses this block.

Parameters:
DB_CYCLES, 8, consecutive synchronised cycles a new raw level must hold before the debounced level changes (legal: >=2)
RPT_DELAY, 32, cycles from the press strobe to the first repeat strobe (legal: >=RPT_PERIOD)
RPT_PERIOD, 8, cycles between subsequent repeat strobes (legal: >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
up_btn  in  1  raw up button, asynchronous, active-high
down_btn  in  1  raw down button, asynchronous, active-high
load_btn  in  1  raw load button, asynchronous, active-high
up_level  out  1  debounced up state
down_level  out  1  debounced down state
up_pulse  out  1  one-cycle up command strobe
down_pulse  out  1  one-cycle down command strobe
load_pulse  out  1  one-cycle load command strobe

Behaviour:
- Reset: all outputs, synchroniser flops, debounce counters and repeat counters cleared to 0; both FSMs in IDLE. Reset is asynchronous on assert; flops update only on clk edges after deassert.
- Synchroniser: 2-flop per button. A raw change sampled at edge k is visible at the sync output after edge k+1.
- Debounce (per channel):
  - Counter is cleared whenever sync output == stable level.
  - Counter increments while they differ.
  - When the counter reaches DB_CYCLES-1 and they still differ, stable level flips at the next edge and the counter clears.
  - Total latency from raw edge sampled at edge k to level change: edge k+1+DB_CYCLES.
  - Any bounce shorter than DB_CYCLES cycles is ignored.
- Counter widths are $clog2 of the respective parameter plus 1. No wrap: counters saturate or clear per the rules here.
- Pulses are registered. A press strobe is high in exactly the first cycle its level is 1.
- up and down each have an independent FSM with states IDLE, DELAY, REPEAT, LOCK:
  - IDLE: on level rise, emit press strobe and go to DELAY (rpt_cnt=0).
  - DELAY: level low -> IDLE, no strobe. rpt_cnt reaches RPT_DELAY-1 -> strobe, go to REPEAT, rpt_cnt=0.
  - REPEAT: level low -> IDLE. rpt_cnt reaches RPT_PERIOD-1 -> strobe, rpt_cnt=0.
  - LOCK: no strobes; exit to IDLE only when own level is 0.
  - Resulting strobe times for a held button: t0, t0+RPT_DELAY, then every RPT_PERIOD.
- Conflict rule: while up_level and down_level are both 1, both FSMs go to LOCK and no up/down strobes are emitted. This includes the cycle in which the second level rises. Releasing one button leaves the other in LOCK until it too is released.
- Load channel: press strobe only, never repeats.
- Load priority: in a cycle where load_pulse=1, up_pulse and down_pulse are forced to 0.
  - A suppressed press is not replayed.
  - A suppressed repeat is dropped; the repeat timing continues unchanged.
- Release: a level fall never generates a strobe.
- Invariant: at most one of up_pulse, down_pulse, load_pulse is high in any cycle.
- Mid-operation reset: outputs drop immediately (asynchronous). A button held through reset deassertion is re-debounced and produces a fresh press strobe DB_CYCLES+2 edges after rst_n rises.

Optional Feature:
HALFLIFE_AUTO_REPEAT_EN
- Defined: DELAY/REPEAT states and repeat counters are present, as described in Behaviour.
- Undefined: repeat logic is removed.
  - IDLE goes to a HELD state on press; HELD returns to IDLE on release.
  - Exactly one strobe per debounced press.
  - LOCK and load-priority rules are unchanged.
  - RPT_DELAY and RPT_PERIOD are ignored.

Test Plan:
1. Reset then idle: rst_n=0 for 3 cycles, buttons 0 -> all outputs 0, and still 0 for 100 cycles after release.
2. Clean press, defaults: up_btn rises before edge 10 and is held 20 cycles -> up_level=1 and up_pulse=1 at edge 19 only; up_level falls 10 edges after the release edge.
3. Bounce: down_btn toggles every 3 cycles for 24 cycles, then held high -> exactly one down_pulse, DB_CYCLES+2 cycles after the final stable edge.
4. Auto-repeat (macro defined): hold up for 80 cycles after its press strobe at t0 -> up_pulse at t0, t0+32, t0+40, t0+48, ..., t0+80 only if still held; no strobe on release. With the macro undefined -> only t0.
5. Conflict: up held, then down pressed -> no strobes from the down rise onward; release down -> up gives no strobe; release and re-press up -> a new press strobe.
6. Load priority: load and up debounced rising in the same cycle -> load_pulse=1, up_pulse=0; with the macro defined, up's next strobe still occurs at +32.
